alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU, sitting in the EX stage of the pipelined CPU.
- Simple ops (AND/OR/ADD/SUB/SLT) complete in 1 cycle; MUL and DIVU/REMU run iteratively over WIDTH cycles.
- Uses a valid/ready handshake so the hazard unit can stall the pipeline while ready_o is low.
- Result and zero flag are registered; data_o holds until the next result.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset (0 = reset)
valid_i  input  1  operation request
ready_o  output  1  block can accept a request this cycle
data1_i  input  WIDTH  operand A
data2_i  input  WIDTH  operand B
ALUCtrl_i  input  3  op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MUL, 100 DIVU, 101 REMU
valid_o  output  1  one-cycle pulse: data_o/zero_o updated
data_o  output  WIDTH  result, held between results
zero_o  output  1  data_o == 0, registered with data_o

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; ready_o=1; valid_o=0; data_o=0; zero_o=1.
  - Counter and working registers are cleared.
  - Reset mid-operation aborts the operation; no valid_o is produced for it.
- Accept: a request is accepted on a rising edge where valid_i=1 and ready_o=1. Operands and op are captured at that edge; later changes are ignored.
- ready_o = (state==IDLE), combinational from state only; valid_i is ignored while ready_o=0.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, undefined code 100..101 excluded):
  - Accepted in cycle c → valid_o=1 and new data_o in cycle c+1. State stays IDLE, so back-to-back accepts give 1 result/cycle.
  - ADD/SUB wrap modulo 2**WIDTH with no overflow flag.
  - SLT: data_o = 1 if signed A < signed B, else 0.
- MUL/DIVU/REMU:
  - Accept in cycle c: state→BUSY, cnt=WIDTH.
  - BUSY occupies cycles c+1..c+WIDTH, ready_o=0. One iteration per edge; cnt decrements.
  - On the edge where cnt==1: final iteration; data_o/zero_o written; valid_o=1 in cycle c+WIDTH+1; state→IDLE, so ready_o=1 in that same cycle.
  - MUL: shift-add, data_o = low WIDTH bits of A*B. Signed and unsigned give the same low bits.
  - DIVU/REMU: restoring unsigned division, WIDTH iterations. DIVU returns the quotient, REMU the remainder.
  - Divide by zero: DIVU → all ones; REMU → A. Latency is unchanged (still WIDTH cycles).
- Undefined ALUCtrl_i codes: not possible with a 3-bit field beyond the list. Any future unused code yields data_o=0, zero_o=1, single-cycle.
- valid_o is high for exactly one cycle per accepted request; never asserted without a prior accept.
- Simultaneous events:
  - A new valid_i in the same cycle valid_o pulses for a multi-cycle op is accepted, since ready_o=1 there.
  - Reset overrides everything.
- No idle toggling: data_o changes only on cycles with valid_o=1.

Test Plan:
- Reset: hold rst_i=0 → ready_o=1, valid_o=0, data_o=0, zero_o=1. Release, idle 5 cycles → outputs unchanged.
- Single-cycle stream: back-to-back requests ADD 7+5, SUB 3-5, AND F0F0_F0F0&0FF0_0FF0, SLT -1<1, one per cycle → valid_o high for 4 consecutive cycles.
  - Expected data_o: 12, FFFF_FFFE, 00F0_00F0, 1.
  - ready_o stays 1 throughout.
- MUL with WIDTH=32: 0x0001_0003 * 0x0002_0005 → ready_o=0 for exactly 32 cycles; valid_o in cycle c+33.
  - Expected data_o = 0x000B_000F (low 32 bits); operand changes during BUSY have no effect.
- DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 9/0 → FFFF_FFFF; REMU 9/0 → 9. Each has latency 33.
- Handshake: MUL in flight with valid_i held high and a different op → not accepted until the valid_o cycle.
  - Second op is accepted on that cycle; its result follows one cycle later.
  - Exactly one valid_o per accept.
- Reset mid-op: assert rst_i=0 at BUSY cycle 10 of DIVU → immediate reset values; no valid_o after release.
  - Repeat with WIDTH=8 and 200/3 → 66, latency 9.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: logic/arith ops finish in one cycle, MUL and
// DIVU/REMU iterate for WIDTH cycles behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  // Handshake: a request transfers on a rising edge with valid_i && ready_o;
  // ready_o depends on state only; valid_o is a one-cycle result pulse.
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic             is_multi;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic [WIDTH-1:0] iter_res;

  assign ready_o  = (state_q == ST_IDLE);
  assign accept   = valid_i & ready_o;
  assign is_multi = (ALUCtrl_i == OP_MUL) | (ALUCtrl_i == OP_DIVU) |
                    (ALUCtrl_i == OP_REMU);

  always_comb begin
    simple_res = '0;
    case (ALUCtrl_i)
      OP_AND:  simple_res = data1_i & data2_i;
      OP_OR:   simple_res = data1_i | data2_i;
      OP_ADD:  simple_res = data1_i + data2_i;
      OP_SUB:  simple_res = data1_i - data2_i;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: simple_res = '0;
    endcase
  end

  // MUL: acc += a when b[0]; a shifts left, b shifts right.
  // DIV: acc is the partial remainder, a shifts the dividend out and the
  // quotient in. A zero divisor always "fits", giving all-ones / remainder A.
  assign mul_acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;
  assign div_shift   = {acc_q, a_q[WIDTH-1]};
  assign div_ge      = (div_shift >= {1'b0, b_q});
  assign div_sub     = WIDTH'(div_shift - {1'b0, b_q});
  assign div_rem_nxt = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_quo_nxt = {a_q[WIDTH-2:0], div_ge};

  always_comb begin
    iter_res = mul_acc_nxt;
    if (op_q == OP_DIVU)      iter_res = div_quo_nxt;
    else if (op_q == OP_REMU) iter_res = div_rem_nxt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept) begin
        if (is_multi) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
          op_d    = ALUCtrl_i;
          a_d     = data1_i;
          b_d     = data2_i;
          acc_d   = '0;
        end else begin
          data_d  = simple_res;
          valid_d = 1'b1;
        end
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (op_q == OP_MUL) begin
        acc_d = mul_acc_nxt;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
      end else begin
        acc_d = div_rem_nxt;
        a_d   = div_quo_nxt;
      end
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        data_d  = iter_res;
        valid_d = 1'b1;
      end
    end
    zero_d = ~|data_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc at WIDTH=32 and WIDTH=8, with
// expected results queued at request time and popped on valid_o.
module tb_alu_mc;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [2:0]  ctrl_i = '0;
  logic        valid_o;
  logic [31:0] data_o;
  logic        zero_o;

  logic        rst8_n = 1'b0;
  logic        valid8_i = 1'b0;
  logic        ready8_o;
  logic [7:0]  a8_i = '0;
  logic [7:0]  b8_i = '0;
  logic [2:0]  ctrl8_i = '0;
  logic        valid8_o;
  logic [7:0]  data8_o;
  logic        zero8_o;

  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  alu_mc #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data1_i(data1_i), .data2_i(data2_i), .ALUCtrl_i(ctrl_i),
    .valid_o(valid_o), .data_o(data_o), .zero_o(zero_o)
  );

  alu_mc #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk_i(clk_i), .rst_i(rst8_n), .valid_i(valid8_i), .ready_o(ready8_o),
    .data1_i(a8_i), .data2_i(b8_i), .ALUCtrl_i(ctrl8_i),
    .valid_o(valid8_o), .data_o(data8_o), .zero_o(zero8_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MUL:  return a * b;
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive one request from a falling edge; returns after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e);
    valid_i = 1'b1;
    ctrl_i  = op;
    data1_i = a;
    data2_i = b;
    exp_q.push_back(e);
    @(negedge clk_i);
  endtask

  // Counts cycles after the accepting edge until valid_o (bounded).
  task automatic wait_done(input string tag, input int exp_lat, input bit sel8);
    int k;
    int busy;
    k = 1;
    busy = 0;
    while (((sel8 ? valid8_o : valid_o) !== 1'b1) && k < 100) begin
      if ((sel8 ? ready8_o : ready_o) === 1'b0) busy++;
      @(negedge clk_i);
      k++;
    end
    chk({tag, " latency"}, k, exp_lat);
    chk({tag, " busy cycles"}, busy, exp_lat - 1);
    chk({tag, " ready at done"}, {31'b0, sel8 ? ready8_o : ready_o}, 32'd1);
  endtask

  always @(negedge clk_i) begin
    logic [31:0] e;
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected valid_o", {31'b0, valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data_o", data_o, e);
        chk("zero_o", {31'b0, zero_o}, {31'b0, (e == 32'd0)});
      end
    end
  end

  always @(negedge clk_i) begin
    logic [7:0] e8;
    if (rst8_n && valid8_o) begin
      if (exp8_q.size() == 0) begin
        chk("unexpected valid8_o", {31'b0, valid8_o}, 32'd0);
      end else begin
        e8 = exp8_q.pop_front();
        chk("data8_o", {24'b0, data8_o}, {24'b0, e8});
        chk("zero8_o", {31'b0, zero8_o}, {31'b0, (e8 == 8'd0)});
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          pulses;

    repeat (3) @(negedge clk_i);
    chk("rst ready", {31'b0, ready_o}, 32'd1);
    chk("rst valid", {31'b0, valid_o}, 32'd0);
    chk("rst data", data_o, 32'd0);
    chk("rst zero", {31'b0, zero_o}, 32'd1);
    rst_n  = 1'b1;
    rst8_n = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("idle ready", {31'b0, ready_o}, 32'd1);
    chk("idle valid", {31'b0, valid_o}, 32'd0);
    chk("idle data", data_o, 32'd0);
    chk("idle zero", {31'b0, zero_o}, 32'd1);

    // Back-to-back single-cycle stream.
    send(OP_ADD, 32'd7, 32'd5, 32'd12);
    chk("stream v1", {31'b0, valid_o}, 32'd1);
    chk("stream r1", {31'b0, ready_o}, 32'd1);
    send(OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE);
    chk("stream v2", {31'b0, valid_o}, 32'd1);
    chk("stream r2", {31'b0, ready_o}, 32'd1);
    send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    chk("stream v3", {31'b0, valid_o}, 32'd1);
    chk("stream r3", {31'b0, ready_o}, 32'd1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    chk("stream v4", {31'b0, valid_o}, 32'd1);
    chk("stream r4", {31'b0, ready_o}, 32'd1);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("stream end valid", {31'b0, valid_o}, 32'd0);
    chk("hold data", data_o, 32'd1);

    // MUL with operand churn while busy.
    send(OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    valid_i = 1'b0;
    data1_i = 32'hDEAD_BEEF;
    data2_i = 32'h1234_5678;
    ctrl_i  = OP_SUB;
    wait_done("mul", 33, 1'b0);
    @(negedge clk_i);

    send(OP_DIVU, 32'd100, 32'd7, 32'd14);
    valid_i = 1'b0;
    wait_done("divu", 33, 1'b0);
    send(OP_REMU, 32'd100, 32'd7, 32'd2);
    valid_i = 1'b0;
    wait_done("remu", 33, 1'b0);
    send(OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    valid_i = 1'b0;
    wait_done("divu by 0", 33, 1'b0);
    send(OP_REMU, 32'd9, 32'd0, 32'd9);
    valid_i = 1'b0;
    wait_done("remu by 0", 33, 1'b0);
    @(negedge clk_i);

    // valid_i held with a different op while MUL is in flight.
    send(OP_MUL, 32'd6, 32'd7, 32'd42);
    valid_i = 1'b1;
    ctrl_i  = OP_ADD;
    data1_i = 32'd10;
    data2_i = 32'd20;
    exp_q.push_back(32'd30);
    wait_done("mul hs", 33, 1'b0);
    @(negedge clk_i);
    chk("hs second valid", {31'b0, valid_o}, 32'd1);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("hs one pulse", {31'b0, valid_o}, 32'd0);

    // Random mix against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      send(op, a, b, model32(op, a, b));
      valid_i = 1'b0;
      wait_done("rand", (op == OP_MUL || op == OP_DIVU || op == OP_REMU) ? 33 : 1, 1'b0);
    end
    @(negedge clk_i);

    // Reset during busy cycle 10 of a DIVU.
    send(OP_DIVU, 32'd100, 32'd7, 32'd14);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst ready", {31'b0, ready_o}, 32'd1);
    chk("midrst valid", {31'b0, valid_o}, 32'd0);
    chk("midrst data", data_o, 32'd0);
    chk("midrst zero", {31'b0, zero_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o === 1'b1) pulses++;
    end
    chk("midrst no valid", pulses, 0);

    // WIDTH=8 instance: DIVU 200/3, then reset mid-operation.
    valid8_i = 1'b1;
    ctrl8_i  = OP_DIVU;
    a8_i     = 8'd200;
    b8_i     = 8'd3;
    exp8_q.push_back(8'd66);
    @(negedge clk_i);
    valid8_i = 1'b0;
    wait_done("divu8", 9, 1'b1);
    @(negedge clk_i);
    valid8_i = 1'b1;
    exp8_q.push_back(8'd66);
    @(negedge clk_i);
    valid8_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst8_n = 1'b0;
    #1;
    exp8_q.delete();
    chk("midrst8 ready", {31'b0, ready8_o}, 32'd1);
    chk("midrst8 valid", {31'b0, valid8_o}, 32'd0);
    chk("midrst8 data", {24'b0, data8_o}, 32'd0);
    chk("midrst8 zero", {31'b0, zero8_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    rst8_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid8_o === 1'b1) pulses++;
    end
    chk("midrst8 no valid", pulses, 0);

    chk("queue drained", exp_q.size(), 0);
    chk("queue8 drained", exp8_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
